// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan controller with a per-slot blanking gap and frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  upd,
    input  logic [5*N_DIGITS-1:0] digits_in,
    output logic [4:0]            dig_code,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_tick,
    output logic                  pending
);
    localparam int TW = $clog2(SCAN_DIV);
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam int DW = 5 * N_DIGITS;

    logic [TW-1:0]       timer_q, timer_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DW-1:0]       staging_q, staging_d, shadow_q, shadow_d;
    logic                pending_q, pending_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [4:0]          dig_code_q, dig_code_d;
    logic                frame_tick_q, frame_tick_d;
    logic                slot_end, boundary, lzb_d;

    always_comb begin
        slot_end  = en && timer_q == TW'(SCAN_DIV - 1);
        boundary  = slot_end && idx_q == IW'(N_DIGITS - 1);
        timer_d   = (!en || slot_end) ? '0 : timer_q + 1'b1;
        idx_d     = (!en || boundary) ? '0 : slot_end ? idx_q + 1'b1 : idx_q;
        staging_d = upd ? digits_in : staging_q;
        shadow_d  = (boundary && pending_q) ? staging_q : shadow_q;
        pending_d = upd || (pending_q && !boundary);
    end

`ifdef SEG_SCAN_LZB_EN
    logic lzb_q, hi_zero;

    // Decided once per slot from the shadow copy the slot will display.
    always_comb begin
        hi_zero = 1'b1;
        for (int k = 0; k < N_DIGITS; k++)
            if (k >= int'(idx_d) && shadow_d[5*k +: 5] != 5'd0) hi_zero = 1'b0;
        lzb_d = (timer_d == '0) ? (hi_zero && idx_d != '0) : lzb_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lzb_q <= 1'b0;
        else        lzb_q <= lzb_d;
`else
    assign lzb_d = 1'b0;
`endif

    // Outputs are derived from next state so they line up with the registered timer.
    always_comb begin
        an_d         = (en && timer_d >= TW'(BLANK_CYC) && !lzb_d) ? ~(N_DIGITS'(1) << idx_d) : '1;
        dig_code_d   = (timer_d == '0) ? shadow_d[5*int'(idx_d) +: 5] : dig_code_q;
        frame_tick_d = en && timer_d == TW'(SCAN_DIV - 1) && idx_d == IW'(N_DIGITS - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q      <= '0;
            idx_q        <= '0;
            staging_q    <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            an_q         <= '1;
            dig_code_q   <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            staging_q    <= staging_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            dig_code_q   <= dig_code_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign dig_code   = dig_code_q;
    assign frame_tick = frame_tick_q;
    assign pending    = pending_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with N_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
module tb_seg_scan_ctrl;
    typedef struct packed {
        logic [3:0] an;
        logic [4:0] dig;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        upd = 1'b0;
    logic [19:0] digits_in = '0;
    logic [4:0]  dig_code;
    logic [3:0]  an;
    logic        frame_tick;
    logic        pending;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    bit   chk_len = 1'b0;
    bit   chk_period = 1'b0;
    int   cyc = 0;
    int   last_tick = -1;
    int   run_len = 0;
    int   blank_len = 0;
    logic [4:0] run_dig = '0;
    logic [3:0] prev_an = 4'hF;
    exp_t e;

    seg_scan_ctrl #(.N_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .upd(upd), .digits_in(digits_in),
        .dig_code(dig_code), .an(an), .frame_tick(frame_tick), .pending(pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] pack(input int d3, input int d2, input int d1, input int d0);
        return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
    endfunction

    // Expected drive runs for the first n slots of a frame showing {d3,d2,d1,d0}.
    task automatic push_frame(input int d3, input int d2, input int d1, input int d0, input int n);
        int   d[4];
        bit   drive;
        exp_t x;
        d = '{d0, d1, d2, d3};
        for (int k = 0; k < n; k++) begin
            drive = 1'b1;
`ifdef SEG_SCAN_LZB_EN
            drive = (k == 0);
            for (int j = k; j < 4; j++) if (d[j] != 0) drive = 1'b1;
`endif
            if (drive) begin
                x.an  = ~(4'd1 << k);
                x.dig = 5'(d[k]);
                q.push_back(x);
            end
        end
    endtask

    task automatic wait_tick();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = frame_tick;
        end
        if (!got) check("tick_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (an != 4'hF) begin
            if (an != prev_an) begin
                if (prev_an != 4'hF && chk_len) check("drive_len", run_len, 6);
`ifndef SEG_SCAN_LZB_EN
                if (prev_an == 4'hF && chk_len) check("blank_len", blank_len, 2);
`endif
                if (q.size() == 0) check("unexp_drive", an, 4'hF);
                else begin
                    e = q.pop_front();
                    check("drive_an", an, e.an);
                    check("drive_dig", dig_code, e.dig);
                end
                run_len = 1;
                run_dig = dig_code;
            end else begin
                run_len++;
                check("dig_stable", dig_code, run_dig);
            end
            check("one_hot", $countones(~an), 1);
            blank_len = 0;
        end else begin
            if (prev_an != 4'hF && chk_len) check("drive_len", run_len, 6);
            blank_len++;
        end
        if (frame_tick) begin
            if (chk_period && last_tick >= 0) check("tick_period", cyc - last_tick, 32);
            last_tick = cyc;
        end
        prev_an = an;
    end

    initial begin
        #1 rst_n = 1'b0;
        #11;
        check("rst_an", an, 4'hF);
        check("rst_dig", dig_code, 0);
        check("rst_tick", frame_tick, 0);
        check("rst_pending", pending, 0);
        #1 rst_n = 1'b1;

        // Basic scan: first frame shows the reset shadow, the next one the update.
        @(posedge clk); #2;
        en = 1'b1; upd = 1'b1; digits_in = pack(3, 2, 1, 0);
        push_frame(0, 0, 0, 0, 4);
        push_frame(3, 2, 1, 0, 4);
        @(posedge clk); #2 upd = 1'b0;
        @(negedge clk) check("t1_pending", pending, 1);
        wait_tick();
        check("t1_pending_tick", pending, 1);
        #1 chk_len = 1'b1; chk_period = 1'b1;
        @(negedge clk) check("t1_pending_drop", pending, 0);
        wait_tick();

        // Update mid slot 1 must not tear the frame in progress.
        push_frame(3, 2, 1, 0, 4);
        push_frame(9, 9, 9, 9, 4);
        repeat (13) @(posedge clk);
        #2 upd = 1'b1; digits_in = pack(9, 9, 9, 9);
        @(posedge clk); #2 upd = 1'b0;
        @(negedge clk);
        check("t2_pending", pending, 1);
        check("t2_old_dig", dig_code, 1);
        wait_tick();
        check("t2_pending_tick", pending, 1);
        @(negedge clk) check("t2_pending_drop", pending, 0);

        // Update landing exactly on the boundary cycle.
        push_frame(7, 7, 7, 7, 4);
        push_frame(5, 5, 5, 5, 3);
        repeat (4) @(posedge clk);
        #2 upd = 1'b1; digits_in = pack(7, 7, 7, 7);
        @(posedge clk); #2 upd = 1'b0;
        wait_tick();
        upd = 1'b1; digits_in = pack(5, 5, 5, 5);
        @(posedge clk); #2 upd = 1'b0;
        @(negedge clk) check("t3_pending_keep", pending, 1);
        wait_tick();
        check("t3_pending_tick", pending, 1);
        @(negedge clk) check("t3_pending_drop", pending, 0);

        // Drop enable mid drive of slot 2, then restart from slot 0.
        repeat (20) @(posedge clk);
        chk_len = 1'b0; chk_period = 1'b0;
        #2 en = 1'b0;
        @(posedge clk);
        @(negedge clk) check("t4_dark", an, 4'hF);
        repeat (8) begin
            @(negedge clk);
            check("t4_dark_hold", an, 4'hF);
            check("t4_no_tick", frame_tick, 0);
        end
        push_frame(5, 5, 5, 5, 4);
        @(posedge clk); #2 en = 1'b1;
        for (int j = 1; j <= 31; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j == 1) check("t4_blank", an, 4'hF);
            if (j == 2) check("t4_slot0", an, 4'hE);
            if (j == 3) chk_len = 1'b1;
            check("t4_tick", frame_tick, j == 31);
        end
        #1 chk_period = 1'b1;

        // Asynchronous reset pulse mid slot 1.
        push_frame(5, 5, 5, 5, 2);
        repeat (5) @(posedge clk);
        #2 upd = 1'b1; digits_in = pack(1, 1, 1, 1);
        @(posedge clk); #2 upd = 1'b0;
        repeat (7) @(posedge clk);
        #3 chk_len = 1'b0; chk_period = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_an", an, 4'hF);
        check("t5_dig", dig_code, 0);
        check("t5_pending", pending, 0);
        check("t5_tick", frame_tick, 0);
        rst_n = 1'b1;

        // After reset: zero frame, then {0,0,4,0}.
        push_frame(0, 0, 0, 0, 4);
        push_frame(0, 0, 4, 0, 4);
        @(posedge clk); #2 upd = 1'b1; digits_in = pack(0, 0, 4, 0);
        @(posedge clk); #2 upd = 1'b0;
        wait_tick();
        #1 chk_len = 1'b1; chk_period = 1'b1;
        wait_tick();
        check("q_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
